// File: rtl/photonic_switch_top.sv
// Two-stage clock-enable divider: 200 MHz -> 8 MHz -> 1 MHz strobes plus derived square waves.
// Latency: strobes are combinational from counter state; counters/toggles update on the next edge.
// Backpressure: none; en=0 freezes all state and forces both strobes low.

// Modular up-counter: advances on inc, wraps TERM -> 0, reset has priority.
// Latency: one clk from inc to new count; term is combinational from the count.
// Backpressure: none; holds while inc=0.
module up_counter #(
    parameter int         W    = 5,
    parameter logic [W-1:0] TERM = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         term
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reset) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign term = (cnt_q == TERM);
endmodule

// Toggle register: inverts on tgl, clears on reset.
// Latency: one clk from tgl to output change.
// Backpressure: none; holds while tgl=0.
module toggle_reg (
    input  logic clk,
    input  logic reset,
    input  logic tgl,
    output logic q
);
    logic tgl_q;
    logic tgl_d;

    always_comb begin
        tgl_d = tgl_q;
        if (reset) begin
            tgl_d = 1'b0;
        end else if (tgl) begin
            tgl_d = ~tgl_q;
        end
    end

    always_ff @(posedge clk) begin
        tgl_q <= tgl_d;
    end

    assign q = tgl_q;
endmodule

// Top: c1 divides clk by DIV_A, c2 divides the c1 strobe by DIV_B.
// Latency: en_8MHz/en_1MHz combinational; temp/pwm_freq/c1/c2 registered.
// Backpressure: none; en=0 holds everything.
module photonic_switch_top #(
    parameter int DIV_A = 25,
    parameter int DIV_B = 8,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          en_8MHz,
    output logic          en_1MHz,
    output logic          temp,
    output logic          pwm_freq,
    output logic [CW-1:0] c1,
    output logic [CW-1:0] c2
);
    localparam logic [CW-1:0] C1_TERM = CW'(DIV_A - 1);
    localparam logic [CW-1:0] C2_TERM = CW'(DIV_B - 1);

    logic run;
    logic c1_term;
    logic c2_term;

    // Gating with reset keeps the strobes low while reset is held.
    assign run     = en & ~reset;
    assign en_8MHz = run & c1_term;
    assign en_1MHz = en_8MHz & c2_term;

    up_counter #(.W(CW), .TERM(C1_TERM)) u_c1 (
        .clk   (clk),
        .reset (reset),
        .inc   (run),
        .cnt   (c1),
        .term  (c1_term)
    );

    up_counter #(.W(CW), .TERM(C2_TERM)) u_c2 (
        .clk   (clk),
        .reset (reset),
        .inc   (en_8MHz),
        .cnt   (c2),
        .term  (c2_term)
    );

    toggle_reg u_temp (
        .clk   (clk),
        .reset (reset),
        .tgl   (en_8MHz),
        .q     (temp)
    );

    toggle_reg u_pwm (
        .clk   (clk),
        .reset (reset),
        .tgl   (en_1MHz),
        .q     (pwm_freq)
    );
endmodule

// File: tb/tb_photonic_switch_top.sv
// Bench for photonic_switch_top: tick-count reference model plus directed scenarios and random en/reset.
module tb_photonic_switch_top;
    localparam int DIV_A = 25;
    localparam int DIV_B = 8;
    localparam int CW    = 5;

    logic          clk;
    logic          reset;
    logic          en;
    logic          en_8MHz;
    logic          en_1MHz;
    logic          temp;
    logic          pwm_freq;
    logic [CW-1:0] c1;
    logic [CW-1:0] c2;

    int checks   = 0;
    int failures = 0;

    // Model state: number of enabled edges since the last reset edge.
    longint ticks = 0;
    bit     model_valid = 0;

    photonic_switch_top #(.DIV_A(DIV_A), .DIV_B(DIV_B), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .en_8MHz  (en_8MHz),
        .en_1MHz  (en_1MHz),
        .temp     (temp),
        .pwm_freq (pwm_freq),
        .c1       (c1),
        .c2       (c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            ticks = 0;
            model_valid = 1;
        end else if (en) begin
            ticks = ticks + 1;
        end
    end

    // Expected outputs follow directly from the enabled-tick count.
    always @(negedge clk) begin
        if (model_valid) begin
            longint slow;
            bit exp8;
            bit exp1;
            slow = ticks / DIV_A;
            exp8 = en && !reset && ((ticks % DIV_A) == DIV_A - 1);
            exp1 = exp8 && ((slow % DIV_B) == DIV_B - 1);
            chk("m_c1", longint'(c1), ticks % DIV_A);
            chk("m_c2", longint'(c2), slow % DIV_B);
            chk("m_temp", longint'(temp), slow % 2);
            chk("m_pwm", longint'(pwm_freq), (ticks / (DIV_A * DIV_B)) % 2);
            chk("m_en8", longint'(en_8MHz), longint'(exp8));
            chk("m_en1", longint'(en_1MHz), longint'(exp1));
        end
    end

    task automatic cyc(input logic e, input logic r, output logic o8, output logic o1);
        en    = e;
        reset = r;
        @(negedge clk);
        o8 = en_8MHz;
        o1 = en_1MHz;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic o8, o1;
        int   n8, n1, k;
        bit   found;

        en    = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        cyc(1'b0, 1'b1, o8, o1);
        cyc(1'b0, 1'b1, o8, o1);
        chk("rst_c1", c1, 0);
        chk("rst_c2", c2, 0);
        chk("rst_temp", temp, 0);
        chk("rst_pwm", pwm_freq, 0);

        // 200 enabled clocks: 8 fast strobes, exactly one slow strobe
        n8 = 0;
        n1 = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == 24) chk("c1_before_wrap", c1, 24);
            cyc(1'b1, 1'b0, o8, o1);
            n8 += int'(o8);
            n1 += int'(o1);
            if (i == 24) begin
                chk("first_en8", o8, 1);
                chk("c1_wrapped", c1, 0);
                chk("temp_after_first", temp, 1);
                chk("en8_count_25", n8, 1);
            end
            if (o1) begin
                chk("en1_at_index", i, 199);
            end
        end
        chk("en8_count_200", n8, 8);
        chk("en1_count_200", n1, 1);
        chk("pwm_after_200", pwm_freq, 1);
        chk("c2_wrapped", c2, 0);
        chk("temp_after_200", temp, 0);

        // Enable gap mid-period
        cyc(1'b0, 1'b1, o8, o1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, o8, o1);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, o8, o1);
            chk("gap_en8", o8, 0);
            chk("gap_c1", c1, 5);
        end
        found = 0;
        k = 0;
        while (!found && k < 40) begin
            k++;
            cyc(1'b1, 1'b0, o8, o1);
            if (o8) found = 1;
        end
        chk("resume_first_en8", found ? k : -1, 20);

        // en dropped exactly at the terminal count
        cyc(1'b0, 1'b1, o8, o1);
        for (int i = 0; i < 24; i++) cyc(1'b1, 1'b0, o8, o1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, o8, o1);
            chk("hold_term_en8", o8, 0);
            chk("hold_term_temp", temp, 0);
            chk("hold_term_c2", c2, 0);
        end
        chk("hold_term_c1", c1, 24);
        cyc(1'b1, 1'b0, o8, o1);
        chk("resume_term_en8", o8, 1);
        chk("resume_term_temp", temp, 1);
        chk("resume_term_c2", c2, 1);

        // Mid-run reset for two clocks
        cyc(1'b0, 1'b1, o8, o1);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, o8, o1);
        chk("mid_c1", c1, 12);
        cyc(1'b1, 1'b1, o8, o1);
        cyc(1'b1, 1'b1, o8, o1);
        chk("midrst_c1", c1, 0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, o8, o1);
        chk("midrst_restart_c1", c1, 3);

        // Reset coincident with both terminal counts
        cyc(1'b0, 1'b1, o8, o1);
        for (int i = 0; i < 199; i++) cyc(1'b1, 1'b0, o8, o1);
        chk("pre_c1", c1, 24);
        chk("pre_c2", c2, 7);
        cyc(1'b1, 1'b1, o8, o1);
        chk("coinc_en8", o8, 0);
        chk("coinc_en1", o1, 0);
        chk("coinc_c1", c1, 0);
        chk("coinc_c2", c2, 0);
        chk("coinc_temp", temp, 0);
        chk("coinc_pwm", pwm_freq, 0);

        // Random enable and occasional reset, checked by the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) != 0, ($urandom % 60) == 0, o8, o1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
